// File: rtl/oam_dma.sv
// oam_dma -- sprite attribute DMA initiator.
//
// Copies LENGTH bytes from page {src_page, 8'h00} to DEST over the shared
// windowed memory bus, one byte per READ / WAIT x LATENCY / WRITE sequence.
// The bus fabric sees registered load/store strobes, address and write data.
// Read data returns LATENCY cycles after the load.
//
// Ports:
//   clock     in   1  rising-edge clock
//   reset     in   1  synchronous, active-high reset
//   start     in   1  one-cycle trigger (CPU write to the DMA register)
//   src_page  in   8  source high byte, sampled with start
//   address   out 16  bus address (registered)
//   indata    out  8  bus write data (registered)
//   outdata   in   8  bus read data, valid LATENCY cycles after load
//   load      out  1  bus read strobe (registered)
//   store     out  1  bus write strobe (registered)
//   busy      out  1  transfer in progress (registered)
//   done      out  1  one-cycle pulse after the final store (registered)
module oam_dma #(
  parameter int          LENGTH  = 160,
  parameter logic [15:0] DEST    = 16'hFE00,
  parameter int          LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  src_page,
  output logic [15:0] address,
  output logic [7:0]  indata,
  input  logic [7:0]  outdata,
  output logic        load,
  output logic        store,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam logic [7:0] LAST_INDEX = 8'(LENGTH - 1);
  localparam logic [7:0] LAST_WAIT  = 8'(LATENCY - 1);

  // Echo RAM (0xE0xx and up) aliases work RAM 0x20 pages lower.
  function automatic logic [7:0] remap_page(input logic [7:0] page);
    if (page >= 8'hE0) begin
      return page - 8'h20;
    end else begin
      return page;
    end
  endfunction

  state_t      state_r, state_s;
  logic [7:0]  index_r, index_s;
  logic [7:0]  page_r, page_s;
  logic [7:0]  wait_r, wait_s;
  logic [7:0]  data_q_r, data_q_s;
  logic        done_s;
  logic        load_s, store_s, busy_s;
  logic [15:0] address_s;
  logic [7:0]  indata_s;

  // Next-state logic; a start always wins and restarts from index 0.
  always_comb begin
    state_s  = state_r;
    index_s  = index_r;
    page_s   = page_r;
    wait_s   = wait_r;
    data_q_s = data_q_r;
    done_s   = 1'b0;
    if (start) begin
      // Abort or fresh start: captured data of an old transfer is dropped
      // and no done pulse is produced for it.
      state_s  = READ;
      index_s  = 8'd0;
      page_s   = remap_page(src_page);
      wait_s   = 8'd0;
      data_q_s = 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        READ: begin
          state_s = WAIT;
          wait_s  = 8'd0;
        end
        WAIT: begin
          if (wait_r == LAST_WAIT) begin
            // outdata is only trusted on the last wait cycle.
            state_s  = WRITE;
            data_q_s = outdata;
          end else begin
            wait_s = wait_r + 8'd1;
          end
        end
        WRITE: begin
          // 8-bit index wraps naturally when LENGTH is 256.
          index_s = index_r + 8'd1;
          if (index_r == LAST_INDEX) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = READ;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Bus outputs are derived from the next state so the registered copies
  // line up with the state they describe.
  always_comb begin
    load_s  = (state_s == READ);
    store_s = (state_s == WRITE);
    busy_s  = (state_s != IDLE);
    case (state_s)
      READ: begin
        address_s = {page_s, index_s};
        indata_s  = 8'd0;
      end
      WRITE: begin
        address_s = DEST + {8'd0, index_s};
        indata_s  = data_q_s;
      end
      default: begin
        address_s = 16'd0;
        indata_s  = 8'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= IDLE;
      index_r  <= 8'd0;
      page_r   <= 8'd0;
      wait_r   <= 8'd0;
      data_q_r <= 8'd0;
      address  <= 16'd0;
      indata   <= 8'd0;
      load     <= 1'b0;
      store    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_r  <= state_s;
      index_r  <= index_s;
      page_r   <= page_s;
      wait_r   <= wait_s;
      data_q_r <= data_q_s;
      address  <= address_s;
      indata   <= indata_s;
      load     <= load_s;
      store    <= store_s;
      busy     <= busy_s;
      done     <= done_s;
    end
  end

endmodule
